data_mem_sized: RTL

Parametrised byte-addressable data memory for the load/store stage, successor to the fixed 1 KiB 64-bit data RAM. It adds RISC-V sized accesses (byte/half/word/double), sign/zero extension of loads and a registered read path with a valid/ready request handshake. It also runs a post-reset clear sequence and optionally traps misaligned accesses. It sits between the MEM stage and the memory array; one request per cycle, fixed one-cycle response latency.

---
 rtl/data_mem_if.sv | 25 ++
 rtl/data_mem_sized.sv | 115 +++++++++++
 2 files changed

// File: rtl/data_mem_if.sv
// Request/response bus between the MEM stage and data_mem_sized.
// master = load/store unit, slave = memory.
interface data_mem_if #(
   parameter int ADDR_W = 64
) ();
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [63:0]       req_wdata;
   logic              rsp_valid;
   logic [63:0]       rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );
   modport slave (
      input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/data_mem_sized.sv
// Byte-addressable data memory with sized loads/stores, post-reset clear and a
// one-cycle registered response. Define DATA_MEM_MISALIGN_TRAP_EN to fault misaligned accesses.
module data_mem_sized #(
   parameter int DEPTH_BYTES = 1024,
   parameter int ADDR_W      = 64
) (
   input  logic        clk,
   input  logic        rst,
   data_mem_if.slave   bus,
   output logic        init_done
);
   localparam int AW = $clog2(DEPTH_BYTES);
   localparam int CW = AW - 3;

   typedef enum logic {CLEAR, RUN} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [7:0]    mem [DEPTH_BYTES];
   logic [AW-1:0] ea;
   logic [7:0]    be;
   logic [63:0]   raw, ld;
   logic          misal, trap, accept, do_wr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      cnt_nx        = cnt;
      bus.req_ready = 1'b0;
      init_done     = 1'b0;
      case (state)
         CLEAR: begin
            cnt_nx = cnt + 1'b1;
            if (&cnt) state_nx = RUN;
         end
         RUN: begin
            // a request seen alongside reset is not accepted
            bus.req_ready = !rst;
            init_done     = 1'b1;
         end
         default: state_nx = CLEAR;
      endcase
   end

   assign ea     = bus.req_addr[AW-1:0];
   assign accept = bus.req_valid && bus.req_ready;

   always_comb begin
      be    = 8'h01;
      misal = 1'b0;
      case (bus.req_size)
         2'd0: begin be = 8'h01; misal = 1'b0;      end
         2'd1: begin be = 8'h03; misal = ea[0];     end
         2'd2: begin be = 8'h0F; misal = |ea[1:0];  end
         default: begin be = 8'hFF; misal = |ea[2:0]; end
      endcase
   end

`ifdef DATA_MEM_MISALIGN_TRAP_EN
   assign trap = misal;
`else
   assign trap = 1'b0;
`endif

   assign do_wr = accept && bus.req_we && !trap;

   // byte lanes wrap individually past the top of the array
   always_comb begin
      raw = '0;
      for (int i = 0; i < 8; i++) raw[8*i +: 8] = mem[ea + AW'(i)];
   end

   always_comb begin
      ld = raw;
      case (bus.req_size)
         2'd0: ld = bus.req_unsigned ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
         2'd1: ld = bus.req_unsigned ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
         2'd2: ld = bus.req_unsigned ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
         default: ld = raw;
      endcase
   end

   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         for (int i = 0; i < 8; i++) mem[{cnt, 3'(i)}] <= 8'h00;
      end else if (do_wr) begin
         for (int i = 0; i < 8; i++)
            if (be[i]) mem[ea + AW'(i)] <= bus.req_wdata[8*i +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= 1'b0;
      end else begin
         bus.rsp_valid <= accept;
         bus.rsp_err   <= accept && trap;
         bus.rsp_rdata <= (accept && !bus.req_we && !trap) ? ld : '0;
      end
   end

   logic unused;
   assign unused = ^{bus.req_addr[ADDR_W-1:AW], misal};
endmodule
